// File: rtl/bp_train_scheduler.sv
// bp_train_scheduler: queues resolved branches, arbitrates the weight-table read port and trains perceptron rows
module bp_train_scheduler #(
    parameter int ROWS   = 228,
    parameter int NW     = 8,
    parameter int WW     = 9,
    parameter int SUMW   = 12,
    parameter int THETA  = 27,
    parameter int FDEPTH = 4,
    parameter int STARVE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 res_valid,
    output logic                 res_ready,
    input  logic [7:0]           res_row,
    input  logic [NW-2:0]        res_hist,
    input  logic                 res_pred,
    input  logic                 res_taken,
    input  logic [SUMW-1:0]      res_sum,
    input  logic                 lk_req,
    input  logic [7:0]           lk_row,
    output logic                 lk_grant,
    output logic                 tbl_rd_en,
    output logic [7:0]           tbl_rd_row,
    input  logic [NW*WW-1:0]     tbl_rd_data,
    output logic                 tbl_wr_en,
    output logic [7:0]           tbl_wr_row,
    output logic [NW*WW-1:0]     tbl_wr_data,
    output logic                 mispredict,
    output logic                 fix_dir,
    output logic                 busy
);
    localparam int AW   = $clog2(FDEPTH);
    localparam int SW   = $clog2(STARVE + 1);
    localparam int RECW = 8 + NW - 1 + 2 + SUMW;
    localparam logic [7:0] LAST  = 8'(ROWS - 1);
    localparam logic [7:0] NROWS = 8'(ROWS);
    localparam logic [SW-1:0] STV = SW'(STARVE);
    localparam logic [AW:0] TWO = (AW + 1)'(2);
    localparam logic signed [SUMW-1:0] TH = SUMW'(THETA);
    localparam logic signed [WW-1:0] WMAX = {1'b0, {(WW - 1){1'b1}}};
    localparam logic signed [WW-1:0] WMIN = {1'b1, {(WW - 1){1'b0}}};
    localparam logic [WW-1:0] ONE = WW'(1);

    typedef enum logic [2:0] {INIT, IDLE, REQ, CALC, WRITE} state_t;

    state_t state;
    logic [7:0] cnt;
    logic [SW-1:0] starve;
    logic sweep;
    logic [RECW-1:0] fifo [FDEPTH];
    logic [AW:0] wp, rp, fcnt;
    logic [AW-1:0] rp_n;
    logic empty, full, push, pop, t_win, h_ok, nxt_ok;
    logic [RECW-1:0] in_rec, h, nxt;
    logic [7:0] h_row;
    logic [NW-2:0] h_hist;
    logic h_taken;
    logic [NW-1:0] xv;
    logic [NW*WW-1:0] nw;

    // record is trainable on a mispredict or a low-confidence sum, and only for a real row;
    // the most negative sum lies outside the symmetric window and is never trainable
    function automatic logic trainable(input logic [RECW-1:0] r);
        logic signed [SUMW-1:0] s;
        s = r[SUMW-1:0];
        return (r[SUMW+1] != r[SUMW] || (s >= -TH && s <= TH)) && r[RECW-1 -: 8] < NROWS;
    endfunction

    assign in_rec   = {res_row, res_hist, res_pred, res_taken, res_sum};
    assign fcnt     = wp - rp;
    assign empty    = wp == rp;
    assign full     = fcnt[AW];
    assign rp_n     = rp[AW-1:0] + 1'b1;
    assign h        = fifo[rp[AW-1:0]];
    assign h_row    = h[RECW-1 -: 8];
    assign h_hist   = h[SUMW+2 +: NW-1];
    assign h_taken  = h[SUMW];
    assign h_ok     = trainable(h);
    assign nxt      = fcnt >= TWO ? fifo[rp_n] : in_rec;
    assign nxt_ok   = (fcnt >= TWO || push) && trainable(nxt);
    assign res_ready = !full && state != INIT && !sweep;
    assign push     = res_valid && res_ready;
    assign pop      = (state == IDLE && !empty && !h_ok) || state == WRITE;
    assign t_win    = state == REQ && (!lk_req || starve == STV);
    assign lk_grant = lk_req && !t_win;
    assign tbl_rd_en  = lk_grant || t_win;
    assign tbl_rd_row = lk_grant ? lk_row : t_win ? h_row : 8'd0;
    assign busy     = state != IDLE || !empty;
    assign xv       = {h_hist, 1'b1};

    for (genvar k = 0; k < NW; k++) begin : g_w
        logic signed [WW-1:0] w;
        logic up;
        assign w  = tbl_rd_data[k*WW +: WW];
        assign up = h_taken == xv[k];
        assign nw[k*WW +: WW] = up ? (w == WMAX ? w : w + ONE) : (w == WMIN ? w : w - ONE);
    end

    // resolution FIFO storage, written on every accepted record
    always_ff @(posedge clk)
        if (push) fifo[wp[AW-1:0]] <= in_rec;

    // FIFO pointers
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end

    // sweep / train sequencer with registered write port and repair pulse
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state       <= INIT;
            cnt         <= '0;
            starve      <= '0;
            sweep       <= 1'b0;
            tbl_wr_en   <= 1'b0;
            tbl_wr_row  <= '0;
            tbl_wr_data <= '0;
            mispredict  <= 1'b0;
            fix_dir     <= 1'b0;
        end else begin
            mispredict <= push && res_pred != res_taken;
            fix_dir    <= push && res_pred != res_taken && res_taken;
            tbl_wr_en  <= 1'b0;
            sweep      <= 1'b0;
            case (state)
                INIT: begin
                    tbl_wr_en   <= 1'b1;
                    tbl_wr_row  <= cnt;
                    tbl_wr_data <= '0;
                    sweep       <= 1'b1;
                    cnt         <= cnt + 1'b1;
                    if (cnt == LAST) state <= IDLE;
                end
                IDLE: if (!empty && h_ok) state <= REQ;
                REQ: begin
                    starve <= t_win ? '0 : starve + 1'b1;
                    if (t_win) state <= CALC;
                end
                CALC: begin
                    tbl_wr_en   <= 1'b1;
                    tbl_wr_row  <= h_row;
                    tbl_wr_data <= nw;
                    state       <= WRITE;
                end
                WRITE: state <= nxt_ok ? REQ : IDLE;
                default: state <= INIT;
            endcase
        end
endmodule

// File: tb/tb_bp_train_scheduler.sv
// tb_bp_train_scheduler: scoreboard bench for the perceptron training scheduler
module tb_bp_train_scheduler;
    logic clk = 1'b0;
    logic rst;
    logic res_valid, res_ready, res_pred, res_taken;
    logic [7:0] res_row, lk_row, tbl_rd_row, tbl_wr_row;
    logic [6:0] res_hist;
    logic [11:0] res_sum;
    logic lk_req, lk_grant, tbl_rd_en, tbl_wr_en, mispredict, fix_dir, busy;
    logic [71:0] tbl_rd_data, tbl_wr_data;

    logic [71:0] tbl [0:227];
    logic [71:0] shadow [0:227];
    logic [79:0] exp_wr [$];
    logic exp_mp [$];
    int n_vec = 0, n_err = 0, cyc = 0, last_wr = 0, last_mp = 0;
    logic mon_en = 1'b0;

    bp_train_scheduler dut (
        .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row),
        .res_hist(res_hist), .res_pred(res_pred), .res_taken(res_taken), .res_sum(res_sum),
        .lk_req(lk_req), .lk_row(lk_row), .lk_grant(lk_grant), .tbl_rd_en(tbl_rd_en),
        .tbl_rd_row(tbl_rd_row), .tbl_rd_data(tbl_rd_data), .tbl_wr_en(tbl_wr_en),
        .tbl_wr_row(tbl_wr_row), .tbl_wr_data(tbl_wr_data), .mispredict(mispredict),
        .fix_dir(fix_dir), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (tbl_rd_en) tbl_rd_data <= tbl_rd_row < 8'd228 ? tbl[tbl_rd_row] : 72'd0;
        if (tbl_wr_en && tbl_wr_row < 8'd228) tbl[tbl_wr_row] <= tbl_wr_data;
    end

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] train(input logic [71:0] w, input logic [6:0] hist, input logic t);
        logic [71:0] r;
        for (int k = 0; k < 8; k++) begin
            logic signed [8:0] x;
            logic xb;
            int v;
            x = w[k*9 +: 9];
            xb = k == 0 ? 1'b1 : hist[k-1];
            v = int'(x) + (t == xb ? 1 : -1);
            if (v > 255) v = 255;
            if (v < -256) v = -256;
            r[k*9 +: 9] = 9'(v);
        end
        return r;
    endfunction

    // scoreboard consumer: table writes and repair pulses
    always @(negedge clk) begin
        logic [79:0] e;
        if (mon_en && tbl_wr_en) begin
            last_wr = cyc;
            if (exp_wr.size() == 0) chk("wr_unexpected", {tbl_wr_row, tbl_wr_data}, 80'd0);
            else begin
                e = exp_wr.pop_front();
                chk("wr", {tbl_wr_row, tbl_wr_data}, e);
            end
        end
        if (mon_en && mispredict) begin
            last_mp = cyc;
            if (exp_mp.size() == 0) chk("mp_unexpected", 80'(fix_dir), 80'd2);
            else chk("fix_dir", 80'(fix_dir), 80'(exp_mp.pop_front()));
        end
    end

    task automatic push(input logic [7:0] row, input logic [6:0] hist, input logic pred,
                        input logic taken, input logic [11:0] sum);
        logic [71:0] w;
        if ((pred != taken || ($signed(sum) >= -27 && $signed(sum) <= 27)) && row < 8'd228) begin
            w = train(shadow[row], hist, taken);
            shadow[row] = w;
            exp_wr.push_back({row, w});
        end
        if (pred != taken) exp_mp.push_back(taken);
        res_valid = 1'b1; res_row = row; res_hist = hist; res_pred = pred; res_taken = taken; res_sum = sum;
        @(posedge clk);
        #1 res_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("idle", 80'(busy), 80'd0);
    endtask

    task automatic sweep();
        int n = 0;
        int g = 0;
        @(negedge clk);
        while (!tbl_wr_en && g < 10) begin
            @(negedge clk);
            g++;
        end
        while (tbl_wr_en && n < 300) begin
            chk("sweep_wr", {tbl_wr_row, tbl_wr_data}, {8'(n), 72'd0});
            chk("sweep_ready", 80'(res_ready), 80'd0);
            n++;
            @(negedge clk);
        end
        chk("sweep_len", 80'(n), 80'd228);
        chk("ready_after", 80'(res_ready), 80'd1);
        chk("busy_after", 80'(busy), 80'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx;
        for (int i = 0; i < 228; i++) shadow[i] = '0;
        rst = 1'b0; res_valid = 1'b0; res_row = '0; res_hist = '0; res_pred = 1'b0;
        res_taken = 1'b0; res_sum = '0; lk_req = 1'b0; lk_row = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", 80'(tbl_wr_en), 80'd0);
        chk("rst_outs", {74'd0, res_ready, lk_grant, tbl_rd_en, mispredict, fix_dir, busy}, 80'd1);
        rst = 1'b1;
        sweep();
        mon_en = 1'b1;

        // mispredict on a zero row: repair pulse next cycle, write three cycles later
        push(8'd5, 7'h7F, 1'b1, 1'b0, 12'd40);
        @(negedge clk);
        chk("mp_pulse", {78'd0, mispredict, fix_dir}, 80'b10);
        wait_idle();
        chk("wr_latency", 80'(last_wr - last_mp), 80'd3);
        chk("row5", tbl[5], {8{9'h1FF}});

        // confident correct prediction: popped in one cycle with no table access
        push(8'd6, 7'h00, 1'b1, 1'b1, 12'd100);
        @(negedge clk);
        chk("skip_busy", {78'd0, busy, tbl_rd_en}, 80'b10);
        @(negedge clk);
        chk("skip_done", 80'(busy), 80'd0);
        push(8'd7, 7'h15, 1'b0, 1'b0, -12'sd27);
        wait_idle();
        push(8'd8, 7'h15, 1'b1, 1'b1, 12'd28);
        @(negedge clk);
        @(negedge clk);
        chk("skip28", 80'(busy), 80'd0);
        push(8'd9, 7'h15, 1'b1, 1'b1, 12'h800);
        wait_idle();
        push(8'd230, 7'h15, 1'b1, 1'b0, 12'd0);
        wait_idle();

        // saturation at both rails
        tbl[10] <= {8{9'h0FF}}; shadow[10] = {8{9'h0FF}};
        tbl[11] <= {8{9'h100}}; shadow[11] = {8{9'h100}};
        push(8'd10, 7'h7F, 1'b1, 1'b1, 12'd0);
        wait_idle();
        push(8'd11, 7'h7F, 1'b0, 1'b0, 12'd0);
        wait_idle();
        chk("sat_hi", tbl[10], {8{9'h0FF}});
        chk("sat_lo", tbl[11], {8{9'h100}});

        // starvation: fetch loses exactly in the fifth REQ cycle
        lk_req = 1'b1; lk_row = 8'd3;
        push(8'd20, 7'h2A, 1'b1, 1'b0, 12'd5);
        idx = 0;
        for (int i = 1; i <= 12 && idx == 0; i++) begin
            @(negedge clk);
            if (!lk_grant) begin
                idx = i;
                chk("starve_port", {70'd0, tbl_rd_en, 1'b0, tbl_rd_row}, {70'd0, 2'b10, 8'd20});
            end
        end
        chk("starve_cycle", 80'(idx), 80'd6);
        @(negedge clk);
        chk("grant_back", 80'(lk_grant), 80'd1);
        lk_req = 1'b0;
        wait_idle();

        // fill the FIFO while fetch hogs the port, then reset during CALC
        lk_req = 1'b1;
        for (int i = 0; i < 4; i++) push(8'(30 + i), 7'h11, 1'b1, 1'b0, 12'd1);
        @(negedge clk);
        chk("full_ready", 80'(res_ready), 80'd0);
        idx = 0;
        for (int i = 0; i < 12 && idx == 0; i++) begin
            @(negedge clk);
            if (!lk_grant) idx = 1;
        end
        chk("win_seen", 80'(idx), 80'd1);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b0;
        exp_wr.delete();
        lk_req = 1'b0;
        #1;
        chk("rst_mid", {77'd0, tbl_wr_en, res_ready, busy}, 80'b001);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        sweep();
        mon_en = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_busy", 80'(busy), 80'd0);
        chk("wr_q_empty", 80'(exp_wr.size()), 80'd0);
        chk("mp_q_empty", 80'(exp_mp.size()), 80'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
